// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues word fetches, tags in-order responses with their PC, and buffers them for the read stage.
// Optional performance counters are enabled by defining IFQ_PERF_CNT_EN.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    redirect_i,
  input  logic [31:0]             redirect_pc_i,
  output logic                    imem_req_o,
  output logic [31:0]             imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [31:0]             imem_rdata_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             out_instr_o,
  output logic [31:0]             out_pc_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_o,
  output logic [31:0]             perf_drop_o,
  output logic [31:0]             perf_starve_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic req;
  logic grant;
  logic drain;
  logic push;
  logic pop;

  // Credit counts only settled occupancy; a pop in this cycle does not free a slot yet.
  always_comb begin
    req   = rst_i && !redirect_i &&
            (({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));
    grant = req && imem_gnt_i;
    drain = imem_rvalid_i && (drop_cnt != '0);
    push  = imem_rvalid_i && !drain && !redirect_i && (count != CW'(DEPTH));
    pop   = (count != '0) && out_ready_i && !redirect_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        // Everything still in flight belongs to the old path and must be discarded.
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        drop_cnt <= outstanding - CW'(imem_rvalid_i);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (drain) drop_cnt <= drop_cnt - CW'(1);
        if (imem_rvalid_i && !drain) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;
  assign out_valid_o = (count != '0);
  assign out_instr_o = out_valid_o ? instr_mem[rd_ptr] : 32'h0;
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr] : 32'h0;
  assign count_o     = count;

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_fetch_o  <= '0;
      perf_drop_o   <= '0;
      perf_starve_o <= '0;
    end else begin
      perf_fetch_o  <= perf_fetch_o + 32'(push);
      perf_drop_o   <= perf_drop_o + 32'(drain);
      perf_starve_o <= perf_starve_o + 32'(out_ready_i && !out_valid_o);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed, table-driven bench for instr_fetch_queue (DEPTH=4, RESET_PC=0); memory handshakes are scripted per cycle.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_drop;
  logic [31:0] perf_starve;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc),
    .count_o       (count)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_drop_o   (perf_drop),
    .perf_starve_o (perf_starve)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  // Instruction word the scripted memory returns for a given fetch address.
  function automatic logic [31:0] ins(input logic [31:0] p);
    return p ^ 32'h5A5A_0013;
  endfunction

  function automatic vec_t v(input logic gnt, input logic rv, input logic [31:0] rdata,
                             input logic rdy, input logic redir, input logic [31:0] rpc,
                             input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_pc, input logic [2:0] e_cnt);
    vec_t r;
    r.gnt = gnt; r.rv = rv; r.rdata = rdata; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Streaming with one-cycle response latency.
    tbl[0]  = v(1, 0, 0,          1, 0, 0, 1, 32'h00, 0, 0,     0);
    tbl[1]  = v(1, 1, ins(32'h0), 1, 0, 0, 1, 32'h04, 0, 0,     0);
    tbl[2]  = v(1, 1, ins(32'h4), 1, 0, 0, 1, 32'h08, 1, 32'h0, 1);
    tbl[3]  = v(1, 1, ins(32'h8), 1, 0, 0, 1, 32'h0C, 1, 32'h4, 1);
    tbl[4]  = v(0, 1, ins(32'hC), 1, 0, 0, 1, 32'h10, 1, 32'h8, 1);
    // Consumer stalls: queue fills to DEPTH and the request drops.
    tbl[5]  = v(1, 0, 0,           0, 0, 0, 1, 32'h10, 1, 32'hC, 1);
    tbl[6]  = v(1, 1, ins(32'h10), 0, 0, 0, 1, 32'h14, 1, 32'hC, 1);
    tbl[7]  = v(1, 1, ins(32'h14), 0, 0, 0, 1, 32'h18, 1, 32'hC, 2);
    tbl[8]  = v(1, 1, ins(32'h18), 0, 0, 0, 0, 32'h1C, 1, 32'hC, 3);
    tbl[9]  = v(1, 0, 0,           0, 0, 0, 0, 32'h1C, 1, 32'hC, 4);
    tbl[10] = v(1, 0, 0,           1, 0, 0, 0, 32'h1C, 1, 32'hC, 4);
    tbl[11] = v(1, 0, 0,           0, 0, 0, 1, 32'h1C, 1, 32'h10, 3);
    tbl[12] = v(0, 1, ins(32'h1C), 1, 0, 0, 0, 32'h20, 1, 32'h10, 3);
    tbl[13] = v(0, 0, 0,           1, 0, 0, 1, 32'h20, 1, 32'h14, 3);
    tbl[14] = v(1, 0, 0,           0, 0, 0, 1, 32'h20, 1, 32'h18, 2);
    // Redirect coinciding with a push and a pop at count 2.
    tbl[15] = v(1, 1, ins(32'h20), 1, 1, 32'h100, 0, 32'h24, 1, 32'h18, 2);
    // Ungranted request must hold its address.
    tbl[16] = v(0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    tbl[17] = v(0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    tbl[18] = v(0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    tbl[19] = v(0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    tbl[20] = v(0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 0);
    // Three in flight, then redirect: their responses are dropped.
    tbl[21] = v(1, 0, 0, 1, 0, 0,      1, 32'h100, 0, 0, 0);
    tbl[22] = v(1, 0, 0, 1, 0, 0,      1, 32'h104, 0, 0, 0);
    tbl[23] = v(1, 0, 0, 1, 0, 0,      1, 32'h108, 0, 0, 0);
    tbl[24] = v(1, 0, 0, 1, 1, 32'h200, 0, 32'h10C, 0, 0, 0);
    tbl[25] = v(0, 1, ins(32'h100), 1, 0, 0, 1, 32'h200, 0, 0, 0);
    tbl[26] = v(0, 1, ins(32'h104), 1, 0, 0, 1, 32'h200, 0, 0, 0);
    tbl[27] = v(0, 1, ins(32'h108), 1, 0, 0, 1, 32'h200, 0, 0, 0);
    tbl[28] = v(1, 0, 0,            1, 0, 0, 1, 32'h200, 0, 0, 0);
    tbl[29] = v(0, 1, ins(32'h200), 0, 0, 0, 1, 32'h204, 0, 0, 0);
    tbl[30] = v(0, 0, 0,            0, 0, 0, 1, 32'h204, 1, 32'h200, 1);

    // Reset with memory activity that must be ignored.
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(imem_req),  0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count),     0);
    chk("rst_pc",    out_pc,         0);
    chk("rst_instr", out_instr,      0);
    chk("rst_addr",  imem_addr,      0);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      if (k == 0) rst_n = 1'b1;
      imem_gnt = tbl[k].gnt; imem_rvalid = tbl[k].rv; imem_rdata = tbl[k].rdata;
      out_ready = tbl[k].rdy; redirect = tbl[k].redir; redirect_pc = tbl[k].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_req", k),   32'(imem_req),  32'(tbl[k].e_req));
      chk($sformatf("v%0d_addr", k),  imem_addr,      tbl[k].e_addr);
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      chk($sformatf("v%0d_pc", k),    out_pc,         tbl[k].e_pc);
      chk($sformatf("v%0d_instr", k), out_instr,      tbl[k].e_valid ? ins(tbl[k].e_pc) : 32'h0);
      chk($sformatf("v%0d_count", k), 32'(count),     32'(tbl[k].e_cnt));
    end

`ifdef IFQ_PERF_CNT_EN
    chk("perf_fetch",  perf_fetch,  32'd9);
    chk("perf_drop",   perf_drop,   32'd3);
    chk("perf_starve", perf_starve, 32'd15);
`endif

    // Asynchronous reset pulse mid-cycle with an entry queued.
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req),  0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count),     0);
    chk("arst_pc",    out_pc,         0);
    chk("arst_instr", out_instr,      0);
    chk("arst_addr",  imem_addr,      0);
    @(posedge clk); #1;
    rst_n = 1'b1; imem_gnt = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("refetch_req",  32'(imem_req), 1);
    chk("refetch_addr", imem_addr,     32'h0);
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    @(negedge clk);
    chk("refetch_next_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  4  queue entries and max outstanding fetches; power of 2, >=2
  RESET_PC  32'h0  first fetch address after reset
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_i  in  1  sole clock, rising edge
  rst_i  in  1  reset, asynchronous, active-low
  redirect_i  in  1  branch/jump redirect, flush queue
  redirect_pc_i  in  32  new fetch address, valid with redirect_i
  imem_req_o  out  1  fetch request to instruction memory
  imem_addr_o  out  32  fetch address, word aligned
  imem_gnt_i  in  1  request accepted this cycle
  imem_rvalid_i  in  1  in-order response valid
  imem_rdata_i  in  32  response instruction word
  out_valid_o  out  1  queue head valid toward register-read stage
  out_ready_i  in  1  consumer accepts head
  out_instr_o  out  32  head instruction
  out_pc_o  out  32  head PC
  count_o  out  log2(DEPTH)+1  current occupancy

Function
REQ-003 The block SHALL keep fetch_pc; imem_addr_o = fetch_pc; fetch_pc += 4 on each cycle with imem_req_o && imem_gnt_i.
REQ-004 The block SHALL track outstanding (+1 on req&&gnt, -1 on rvalid, same-cycle both: unchanged).
REQ-005 imem_req_o SHALL be asserted iff count_o + outstanding < DEPTH and redirect_i = 0; occupancy freed by a same-cycle pop SHALL not count as credit.
REQ-006 While imem_req_o is high and gnt low, imem_addr_o SHALL hold stable; only redirect may withdraw an ungranted request.
REQ-007 Responses SHALL be tagged with resp_pc, which starts at RESET_PC and increments by 4 per non-discarded response.
REQ-008 A non-discarded response SHALL push {resp_pc, imem_rdata_i} into the FIFO tail; the entry SHALL be visible at the head one cycle later, at the earliest.
REQ-009 out_valid_o SHALL equal (count_o != 0); out_instr_o/out_pc_o SHALL be the head entry when valid and 32'h0 when not.
REQ-010 Pop SHALL occur on out_valid_o && out_ready_i; simultaneous push and pop SHALL leave count_o unchanged.
REQ-011 Overflow is impossible by REQ-005; a push to a full queue SHALL be dropped.
REQ-012 On redirect_i: count_o <= 0, fetch_pc <= redirect_pc_i, resp_pc <= redirect_pc_i, drop_cnt <= outstanding minus rvalid this cycle; any pop or push that cycle SHALL be ignored.
REQ-013 While drop_cnt > 0, each rvalid SHALL be discarded and decrement drop_cnt; a redirect during draining SHALL reload drop_cnt per REQ-012.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-015 Asserted rst_i SHALL immediately force imem_req_o=0, out_valid_o=0, out_instr_o=0, out_pc_o=0, count_o=0, outstanding=0, and drop_cnt=0, and SHALL set fetch_pc=resp_pc=RESET_PC.
REQ-016 The first fetch request SHALL appear in the first cycle after rst_i deasserts.
REQ-017 Responses arriving during reset SHALL be ignored; the memory is reset together with this block.

Configuration
REQ-018 With IFQ_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_fetch_o (pushes), perf_drop_o (discarded responses), and perf_starve_o (cycles with out_ready_i && !out_valid_o), reset to 0 and wrapping at 2^32.
REQ-019 Without IFQ_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-020 Reset release, gnt=1, rvalid one cycle after grant, ready=1 -> out_pc_o 0,4,8,... on consecutive cycles with correct instr.
REQ-021 ready=0, DEPTH=4 -> exactly 4 grants, count_o=4, imem_req_o=0; ready=1 one cycle -> count_o=3, next cycle req=1.
REQ-022 3 outstanding, redirect to 0x100 -> next 3 rvalids discarded, count_o stays 0, first out_pc_o=0x100.
REQ-023 Redirect same cycle as push and pop with count_o=2 -> count_o=0, no entry pushed, imem_req_o=0 that cycle.
REQ-024 gnt held low 5 cycles -> imem_addr_o stable; rst_i pulsed low mid-queue -> all outputs 0 asynchronously, refetch from RESET_PC.
REQ-025 IFQ_PERF_CNT_EN: scenario REQ-022 -> perf_drop_o=3; 10 empty cycles with ready=1 -> perf_starve_o=10.
